// File: rtl/comp_divider_if.sv
// Run/ready handshake bundle for the sequential divider. The master supplies
// operands and run, and the slave returns the registered results and ready.
interface comp_divider_if #(parameter int WIDTH = 32);
    logic [2*WIDTH-1:0] Dividend;
    logic [WIDTH-1:0]   Divisor;
    logic               run;
    logic [WIDTH-1:0]   Quotient;
    logic [WIDTH-1:0]   Remainder;
    logic               error;
    logic               ready;

    modport master (
        output Dividend, Divisor, run,
        input  Quotient, Remainder, error, ready
    );

    modport slave (
        input  Dividend, Divisor, run,
        output Quotient, Remainder, error, ready
    );
endinterface

// File: rtl/comp_divider.sv
// Sequential unsigned restoring divider: 2*WIDTH / WIDTH -> WIDTH quotient and
// remainder, one quotient bit per clock, using the multiplier's run/ready handshake.
module comp_divider #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    comp_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nx;
    // Partial remainder is kept at WIDTH bits: it stays below the divisor between steps.
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] quo, rem;
    logic             err, rdy;

    logic             start_err;
    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] r_diff;
    logic             r_ge;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;
    logic             last_step;

    assign bus.Quotient  = quo;
    assign bus.Remainder = rem;
    assign bus.error     = err;
    assign bus.ready     = rdy;

    // One restoring step: shift {R,Q} left, compare at WIDTH+1 bits, subtract if it fits.
    always_comb begin
        start_err = (bus.Divisor == '0) ||
                    (bus.Dividend[2*WIDTH-1:WIDTH] >= bus.Divisor);
        r_sh      = {r_q, q_q[WIDTH-1]};
        r_ge      = (r_sh >= {1'b0, d_q});
        // The true difference is below D, so the low WIDTH bits hold it exactly.
        r_diff    = r_sh[WIDTH-1:0] - d_q;
        r_next    = r_ge ? r_diff : r_sh[WIDTH-1:0];
        q_next    = {q_q[WIDTH-2:0], r_ge};
        last_step = (cnt == CW'(WIDTH - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.run) state_nx = start_err ? DONE : CALC;
            CALC:    if (last_step) state_nx = DONE;
            DONE:    if (!bus.run) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath and result registers; operands are captured only on the start edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_q <= '0;
            q_q <= '0;
            d_q <= '0;
            cnt <= '0;
            quo <= '0;
            rem <= '0;
            err <= 1'b0;
            rdy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.run) begin
                        d_q <= bus.Divisor;
                        r_q <= bus.Dividend[2*WIDTH-1:WIDTH];
                        q_q <= bus.Dividend[WIDTH-1:0];
                        cnt <= '0;
                        err <= start_err;
                        if (start_err) begin
                            quo <= '1;
                            rem <= bus.Dividend[WIDTH-1:0];
                            rdy <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    r_q <= r_next;
                    q_q <= q_next;
                    cnt <= cnt + CW'(1);
                    if (last_step) begin
                        quo <= q_next;
                        rem <= r_next;
                        rdy <= 1'b1;
                    end
                end
                DONE: begin
                    if (!bus.run) rdy <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule
